// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock flit FIFO for NoC router input ports.
// FIFO_BUFFER_ERR_FLAGS_EN adds sticky overflow/underflow outputs.
module fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  write,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);
  assign wr_ok = write & ~full;
  assign rd_ok = read & ~empty;

  always_comb begin
    cnt_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = count + CNT_ONE;
      2'b01:   cnt_nxt = count - CNT_ONE;
      default: cnt_nxt = count;
    endcase
  end

  // Storage is not reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= Data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      Data_out <= '0;
    end else begin
      count <= cnt_nxt;
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) begin
        Data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
    end
  end

`ifdef FIFO_BUFFER_ERR_FLAGS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write && full)  overflow  <= 1'b1;
      if (read  && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: scoreboard bench for fifo_buffer.
// Checks data order, flags and optional error flags every cycle.
module tb_fifo_buffer;

  logic       clk;
  logic       rst;
  logic [7:0] Data_in;
  logic       write;
  logic       read;
  logic [7:0] Data_out;
  logic       empty;
  logic       full;
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
  logic       overflow;
  logic       underflow;
`endif

  fifo_buffer #(
    .DATA_WIDTH(8),
    .DEPTH(8),
    .ADDR_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Data_in(Data_in),
    .write(write),
    .read(read),
    .Data_out(Data_out),
    .empty(empty),
    .full(full)
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    ,
    .overflow(overflow),
    .underflow(underflow)
`endif
  );

  // Clock held low until reset has been checked without any edge.
  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  int         mdl_cnt = 0;
  logic [7:0] last_out = 8'h00;
  logic       mdl_ovf = 1'b0;
  logic       mdl_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, ".empty"}, 32'(empty), 32'(mdl_cnt == 0));
    chk({tag, ".full"}, 32'(full), 32'(mdl_cnt == 8));
`ifdef FIFO_BUFFER_ERR_FLAGS_EN
    chk({tag, ".ovf"}, 32'(overflow), 32'(mdl_ovf));
    chk({tag, ".unf"}, 32'(underflow), 32'(mdl_unf));
`endif
  endtask

  task automatic op(input string tag, input logic w, input logic r,
                    input logic [7:0] d);
    logic wacc;
    logic racc;
    write   = w;
    read    = r;
    Data_in = d;
    wacc = w && (mdl_cnt < 8);
    racc = r && (mdl_cnt > 0);
    if (w && mdl_cnt == 8) mdl_ovf = 1'b1;
    if (r && mdl_cnt == 0) mdl_unf = 1'b1;
    if (racc) last_out = sb.pop_front();
    if (wacc) sb.push_back(d);
    mdl_cnt = mdl_cnt + int'(wacc) - int'(racc);
    @(posedge clk);
    #1;
    chk({tag, ".dout"}, 32'(Data_out), 32'(last_out));
    chk_flags(tag);
  endtask

  task automatic model_reset();
    sb.delete();
    mdl_cnt  = 0;
    last_out = 8'h00;
    mdl_ovf  = 1'b0;
    mdl_unf  = 1'b0;
  endtask

  initial begin
    write   = 1'b0;
    read    = 1'b0;
    Data_in = 8'h00;
    rst     = 1'b1;
    #1 rst  = 1'b0;
    #15;
    chk("rst.empty", 32'(empty), 32'd1);
    chk("rst.full", 32'(full), 32'd0);
    chk("rst.dout", 32'(Data_out), 32'd0);
    #2 rst = 1'b1;

    for (int i = 1; i <= 11; i++) op("fill", 1'b1, 1'b0, 8'(i));
    for (int i = 0; i < 10; i++) op("drain", 1'b0, 1'b1, 8'h00);
    chk("drain.hold", 32'(Data_out), 32'd8);

    for (int i = 0; i < 4; i++) op("pre4", 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 20; i++) op("rw4", 1'b1, 1'b1, 8'(8'h50 + i));
    for (int i = 0; i < 4; i++) op("post4", 1'b0, 1'b1, 8'h00);

    op("emprw", 1'b1, 1'b1, 8'hA5);
    op("emprd", 1'b0, 1'b1, 8'h00);
    chk("emprd.val", 32'(Data_out), 32'hA5);

    for (int i = 0; i < 5; i++) op("pre5", 1'b1, 1'b0, 8'(8'h60 + i));
    write = 1'b0;
    read  = 1'b0;
    rst   = 1'b0;
    #2;
    model_reset();
    chk("mrst.empty", 32'(empty), 32'd1);
    chk("mrst.full", 32'(full), 32'd0);
    chk("mrst.dout", 32'(Data_out), 32'd0);
    #1 rst = 1'b1;
    op("mrst.wr", 1'b1, 1'b0, 8'h3C);
    op("mrst.rd", 1'b0, 1'b1, 8'h00);
    chk("mrst.val", 32'(Data_out), 32'h3C);

    for (int i = 0; i < 80; i++)
      op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
# fifo_buffer

Synchronous single-clock FIFO used as the per-port input buffer of the NoC router. It stores 8-bit flits written by the upstream link and releases them in arrival order to the router's switching logic. Registered `empty` and `full` status outputs drive the flow control to the neighbouring stages.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: flit width in bits.
- `DEPTH`, default 8: number of entries; must be a power of two ≥ 2.
- `ADDR_WIDTH`, default 3: log2(`DEPTH`), used for pointer width.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted when 0).
- `Data_in` in `DATA_WIDTH`: write data.
- `write` in 1: write request, sampled at the rising edge of `clk`.
- `read` in 1: read request, sampled at the rising edge of `clk`.
- `Data_out` out `DATA_WIDTH`: registered read data.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds `DEPTH` entries.

## Operation

- Storage is a `DEPTH` × `DATA_WIDTH` register array.
- Write pointer `wr_ptr` and read pointer `rd_ptr` are each `ADDR_WIDTH` bits and wrap modulo `DEPTH`.
- Occupancy counter `count` is `ADDR_WIDTH+1` bits wide, range 0..`DEPTH`.
- Write is accepted when `write`=1 and `full`=0:
  - `mem[wr_ptr]` <= `Data_in`.
  - `wr_ptr` increments.
- Read is accepted when `read`=1 and `empty`=0:
  - `Data_out` <= `mem[rd_ptr]`.
  - `rd_ptr` increments.
- `count` rules:
  - Accepted write only: +1.
  - Accepted read only: −1.
  - Both accepted in the same cycle: unchanged.
- Blocked requests:
  - A write while full is dropped; memory and pointers are unchanged, even if `read` is also asserted that cycle.
  - A read while empty is ignored; `Data_out` holds its value.
  - When empty, a simultaneous read and write accepts only the write.
- `Data_out` holds its last value whenever no read is accepted.
- Flags are driven from registered `count`: `empty` = (`count`==0), `full` = (`count`==`DEPTH`).
- Reset (`rst`=0, asynchronous, effective mid-operation):
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `Data_out` goes to 0.
  - `empty` goes to 1, `full` goes to 0.
  - Memory contents are not cleared and are unobservable afterwards.

## Timing

- Write-to-flag latency is one edge: after the edge that accepts the first write, `empty`=0.
- After the edge that accepts the `DEPTH`-th write, `full`=1.
- Read latency is one edge: `Data_out` is valid after the rising edge at which the read is accepted.
- Fall-through is not supported: data written at edge N can first be read at edge N+1.
- After the edge that accepts the last read, `empty`=1.
- `full` deasserts after the edge that accepts a read from a full FIFO.
- Reset release is synchronised externally; the first accepted operation is on the first rising edge with `rst`=1.

## Configuration

- Macro `FIFO_BUFFER_ERR_FLAGS_EN`.
- Defined:
  - Adds outputs `overflow` (1 bit) and `underflow` (1 bit), both sticky and registered.
  - `overflow` sets on any edge with `write`=1 and `full`=1.
  - `underflow` sets on any edge with `read`=1 and `empty`=1.
  - Both clear only on reset; reset value 0.
  - Both set on the edge after the offending request.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

## Test plan

- Reset: drive `rst`=0 for 15 ns with no clock edge -> `empty`=1, `full`=0, `Data_out`=0 immediately.
- Overfill: `write`=1 for 11 cycles with `Data_in`=1..11 -> `full`=1 after the 8th edge; values 9, 10, 11 are dropped; `count` stays 8; with the macro defined, `overflow`=1.
- Drain: `write`=0, `read`=1 for 10 cycles -> `Data_out` = 1,2,…,8 on successive edges; `empty`=1 after the 8th read; `Data_out` holds 8 thereafter; with the macro defined, `underflow`=1.
- Simultaneous read and write at occupancy 4 for 20 cycles -> `count` stays 4; data stays in order across pointer wrap; `full` and `empty` stay 0.
- Simultaneous read and write while empty with `Data_in`=0xA5 -> write accepted, `Data_out` unchanged, `empty`=0 next cycle; a read on the following edge returns 0xA5.
- Reset asserted mid-operation at occupancy 5 -> `empty`=1 and `full`=0 asynchronously; the next written value 0x3C is the first value read back.
